// File: rtl/lsu_ctrl_if.sv
// Handshake bundles around the load/store unit: EXU request/response side and word-wide data bus side.
// On lsu_req_if the EXU is master; on lsu_mem_if the LSU is master.

interface lsu_req_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_wen;
   logic [2:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_rdata;
   logic [1:0]        resp_err;

   modport master (
      output req_valid, req_wen, req_op, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_wen, req_op, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

interface lsu_mem_if #(
   parameter int ADDR_W = 32
);
   logic              mem_valid;
   logic              mem_ready;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wmask;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport master (
      output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
      input  mem_ready, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
      output mem_ready, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/lsu_ctrl.sv
// Multicycle load/store unit: validates one EXU memory op, runs it over a handshaked word bus
// with a bounded latency, and returns exactly one formatted response per accepted request.

module lsu_ctrl #(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic      clk,
   input  logic      rst_n,
   lsu_req_if.slave  req,
   lsu_mem_if.master mem
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_ALIGN   = 2'd1;
   localparam logic [1:0] ERR_ILLEGAL = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam int               CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
   localparam logic             TO_EN    = (TIMEOUT_CYC != 0);

   function automatic logic op_illegal(input logic wen, input logic [2:0] op);
      logic bad;
      if (wen) begin
         bad = (op > 3'd2);
      end else begin
         case (op)
            3'd3, 3'd6, 3'd7: bad = 1'b1;
            default:          bad = 1'b0;
         endcase
      end
      return bad;
   endfunction

   // op[1:0] encodes access size for loads and stores alike (0 byte, 1 half, 2 word)
   function automatic logic misaligned(input logic [2:0] op, input logic [1:0] p);
      logic mis;
      case (op[1:0])
         2'd1:    mis = p[0];
         2'd2:    mis = (p != 2'd0);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

   function automatic logic [35:0] store_lanes(input logic [2:0] op, input logic [1:0] p,
                                               input logic [31:0] wdata);
      logic [3:0]  mask;
      logic [31:0] data;
      case (op[1:0])
         2'd0: begin
            data = {4{wdata[7:0]}};
            mask = 4'b0001 << p;
         end
         2'd1: begin
            data = {2{wdata[15:0]}};
            mask = 4'b0011 << p;
         end
         default: begin
            data = wdata;
            mask = 4'b1111;
         end
      endcase
      return {mask, data};
   endfunction

   function automatic logic [31:0] load_format(input logic [2:0] op, input logic [1:0] p,
                                               input logic [31:0] rdata);
      logic [31:0] sh;
      logic [31:0] res;
      sh = rdata >> {p, 3'b000};
      case (op)
         3'd0:    res = {{24{sh[7]}}, sh[7:0]};
         3'd1:    res = {{16{sh[15]}}, sh[15:0]};
         3'd2:    res = rdata;
         3'd4:    res = {24'd0, sh[7:0]};
         3'd5:    res = {16'd0, sh[15:0]};
         default: res = 32'd0;
      endcase
      return res;
   endfunction

   state_t            state_r;
   state_t            state_nxt_s;
   logic              wen_r;
   logic [2:0]        op_r;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       wdata_r;
   logic [3:0]        wmask_r;
   logic [31:0]       rdata_r;
   logic [1:0]        err_r;
   logic [CNT_W-1:0]  cnt_r;

   logic        accept_s;
   logic        illegal_s;
   logic        misalign_s;
   logic        timeout_s;
   logic [35:0] lanes_s;

   assign accept_s   = req.req_valid && (state_r == IDLE);
   assign illegal_s  = op_illegal(req.req_wen, req.req_op);
   assign misalign_s = misaligned(req.req_op, req.req_addr[1:0]);
   assign timeout_s  = TO_EN && (cnt_r == CNT_LAST);
   assign lanes_s    = store_lanes(req.req_op, req.req_addr[1:0], req.req_wdata);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode; in ISSUE the timeout beats a late mem_ready, in WAIT rvalid beats the timeout
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (req.req_valid) begin
               if (illegal_s || misalign_s) state_nxt_s = DONE;
               else                         state_nxt_s = ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            if (timeout_s)          state_nxt_s = DONE;
            else if (mem.mem_ready) state_nxt_s = WAIT;
            else                    state_nxt_s = ISSUE;
         end
         WAIT: begin
            if (mem.mem_rvalid || timeout_s) state_nxt_s = DONE;
            else                             state_nxt_s = WAIT;
         end
         DONE: begin
            if (req.resp_ready) state_nxt_s = IDLE;
            else                state_nxt_s = DONE;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output decode from the registered state and datapath
   always_comb begin
      req.req_ready  = (state_r == IDLE);
      req.resp_valid = (state_r == DONE);
      req.resp_rdata = rdata_r;
      req.resp_err   = err_r;
      mem.mem_valid  = (state_r == ISSUE);
      mem.mem_wen    = wen_r;
      mem.mem_addr   = {addr_r[ADDR_W-1:2], 2'b00};
      mem.mem_wdata  = wdata_r;
      mem.mem_wmask  = wmask_r;
   end

   // Request latch, store lane build and response capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wen_r   <= 1'b0;
         op_r    <= 3'd0;
         addr_r  <= '0;
         wdata_r <= 32'd0;
         wmask_r <= 4'd0;
         rdata_r <= 32'd0;
         err_r   <= ERR_OK;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  wen_r   <= req.req_wen;
                  op_r    <= req.req_op;
                  addr_r  <= req.req_addr;
                  wdata_r <= req.req_wen ? lanes_s[31:0] : 32'd0;
                  wmask_r <= req.req_wen ? lanes_s[35:32] : 4'd0;
                  rdata_r <= 32'd0;
                  if (illegal_s)       err_r <= ERR_ILLEGAL;
                  else if (misalign_s) err_r <= ERR_ALIGN;
                  else                 err_r <= ERR_OK;
               end
            end
            ISSUE: begin
               if (timeout_s) begin
                  err_r   <= ERR_TIMEOUT;
                  rdata_r <= 32'd0;
               end
            end
            WAIT: begin
               if (mem.mem_rvalid) begin
                  err_r   <= ERR_OK;
                  rdata_r <= wen_r ? 32'd0 : load_format(op_r, addr_r[1:0], mem.mem_rdata);
               end else if (timeout_s) begin
                  err_r   <= ERR_TIMEOUT;
                  rdata_r <= 32'd0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Bus latency counter: zero outside ISSUE/WAIT so it restarts on every entry to ISSUE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if ((state_r == ISSUE) || (state_r == WAIT)) begin
         cnt_r <= cnt_r + 1'b1;
      end else begin
         cnt_r <= '0;
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl (TIMEOUT_CYC=8): each task drives one scenario and checks
// its outputs against hand-computed values.

module tb_lsu_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   lsu_req_if #(.ADDR_W(32)) req_bus ();
   lsu_mem_if #(.ADDR_W(32)) mem_bus ();

   lsu_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_bus),
      .mem   (mem_bus)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Presents one request for a single cycle; returns in cycle T+1
   task automatic issue(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata);
      req_bus.req_wen   = wen;
      req_bus.req_op    = op;
      req_bus.req_addr  = addr;
      req_bus.req_wdata = wdata;
      req_bus.req_valid = 1'b1;
      tick();
      req_bus.req_valid = 1'b0;
   endtask

   // From cycle T+1 (ISSUE): grant at T+1, rvalid at T+2; returns in T+3
   task automatic bus_complete(input logic [31:0] rdata);
      mem_bus.mem_ready = 1'b1;
      tick();
      mem_bus.mem_ready  = 1'b0;
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = rdata;
      tick();
      mem_bus.mem_rvalid = 1'b0;
   endtask

   task automatic release_resp;
      req_bus.resp_ready = 1'b1;
      tick();
      req_bus.resp_ready = 1'b0;
   endtask

   task automatic test_reset;
      #23;
      total++; if (req_bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_bus.req_ready); end
      total++; if (req_bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", req_bus.resp_valid); end
      total++; if (req_bus.resp_rdata !== 32'd0 || req_bus.resp_err !== 2'd0) begin bad++; $display("FAIL rst_resp got=%h/%0d exp=0/0", req_bus.resp_rdata, req_bus.resp_err); end
      total++; if ({mem_bus.mem_valid, mem_bus.mem_wen, mem_bus.mem_wmask} !== 6'd0) begin bad++; $display("FAIL rst_mem_ctl got=%b exp=0", {mem_bus.mem_valid, mem_bus.mem_wen, mem_bus.mem_wmask}); end
      total++; if (mem_bus.mem_addr !== 32'd0 || mem_bus.mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_mem_data got=%h/%h exp=0/0", mem_bus.mem_addr, mem_bus.mem_wdata); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_lb_sign;
      issue(1'b0, 3'd0, 32'h8000_0003, 32'd0);
      total++; if (mem_bus.mem_valid !== 1'b1 || req_bus.req_ready !== 1'b0) begin bad++; $display("FAIL lb_issue got=%b/%b exp=1/0", mem_bus.mem_valid, req_bus.req_ready); end
      total++; if (mem_bus.mem_addr !== 32'h8000_0000) begin bad++; $display("FAIL lb_mem_addr got=%h exp=80000000", mem_bus.mem_addr); end
      total++; if (mem_bus.mem_wen !== 1'b0 || mem_bus.mem_wmask !== 4'd0) begin bad++; $display("FAIL lb_wen_mask got=%b/%b exp=0/0000", mem_bus.mem_wen, mem_bus.mem_wmask); end
      mem_bus.mem_ready = 1'b1;
      tick();
      mem_bus.mem_ready = 1'b0;
      total++; if (mem_bus.mem_valid !== 1'b0 || req_bus.resp_valid !== 1'b0) begin bad++; $display("FAIL lb_wait got=%b/%b exp=0/0", mem_bus.mem_valid, req_bus.resp_valid); end
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = 32'h80FF_1234;
      tick();
      mem_bus.mem_rvalid = 1'b0;
      total++; if (req_bus.resp_valid !== 1'b1) begin bad++; $display("FAIL lb_resp_valid got=%b exp=1", req_bus.resp_valid); end
      total++; if (req_bus.resp_rdata !== 32'hFFFF_FF80 || req_bus.resp_err !== 2'd0) begin bad++; $display("FAIL lb_resp got=%h/%0d exp=ffffff80/0", req_bus.resp_rdata, req_bus.resp_err); end
      release_resp();
      total++; if (req_bus.req_ready !== 1'b1 || req_bus.resp_valid !== 1'b0) begin bad++; $display("FAIL lb_idle got=%b/%b exp=1/0", req_bus.req_ready, req_bus.resp_valid); end
   endtask

   task automatic test_load_formats;
      logic [2:0]  ops [6]   = '{3'd1, 3'd5, 3'd4, 3'd0, 3'd2, 3'd1};
      logic [31:0] addrs [6] = '{32'h0000_0002, 32'h0000_0012, 32'h0000_0021, 32'h0000_0031, 32'h0000_0044, 32'h0000_0050};
      logic [31:0] rds [6]   = '{32'h8001_1234, 32'h8001_1234, 32'h80FF_F234, 32'h0000_7F00, 32'hCAFE_BABE, 32'h1234_F00D};
      logic [31:0] exps [6]  = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_00F2, 32'h0000_007F, 32'hCAFE_BABE, 32'hFFFF_F00D};
      for (int i = 0; i < 6; i++) begin
         issue(1'b0, ops[i], addrs[i], 32'd0);
         total++; if (mem_bus.mem_addr !== (addrs[i] & 32'hFFFF_FFFC)) begin bad++; $display("FAIL ld%0d_mem_addr got=%h exp=%h", i, mem_bus.mem_addr, addrs[i] & 32'hFFFF_FFFC); end
         bus_complete(rds[i]);
         total++; if (req_bus.resp_valid !== 1'b1 || req_bus.resp_rdata !== exps[i] || req_bus.resp_err !== 2'd0) begin bad++; $display("FAIL ld%0d_resp got=%b/%h/%0d exp=1/%h/0", i, req_bus.resp_valid, req_bus.resp_rdata, req_bus.resp_err, exps[i]); end
         release_resp();
      end
   endtask

   task automatic test_store_lanes;
      logic [2:0]  ops [4]   = '{3'd1, 3'd0, 3'd2, 3'd0};
      logic [31:0] addrs [4] = '{32'h0000_0102, 32'h0000_0201, 32'h0000_0308, 32'h0000_0403};
      logic [31:0] wds [4]   = '{32'hABCD_5678, 32'h1234_56AB, 32'h1122_3344, 32'h0000_00C5};
      logic [31:0] expd [4]  = '{32'h5678_5678, 32'hABAB_ABAB, 32'h1122_3344, 32'hC5C5_C5C5};
      logic [3:0]  expm [4]  = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
      for (int i = 0; i < 4; i++) begin
         issue(1'b1, ops[i], addrs[i], wds[i]);
         total++; if (mem_bus.mem_valid !== 1'b1 || mem_bus.mem_wen !== 1'b1) begin bad++; $display("FAIL st%0d_issue got=%b/%b exp=1/1", i, mem_bus.mem_valid, mem_bus.mem_wen); end
         total++; if (mem_bus.mem_wdata !== expd[i] || mem_bus.mem_wmask !== expm[i]) begin bad++; $display("FAIL st%0d_lanes got=%h/%b exp=%h/%b", i, mem_bus.mem_wdata, mem_bus.mem_wmask, expd[i], expm[i]); end
         total++; if (mem_bus.mem_addr !== (addrs[i] & 32'hFFFF_FFFC)) begin bad++; $display("FAIL st%0d_mem_addr got=%h exp=%h", i, mem_bus.mem_addr, addrs[i] & 32'hFFFF_FFFC); end
         bus_complete(32'hDEAD_BEEF);
         total++; if (req_bus.resp_valid !== 1'b1 || req_bus.resp_rdata !== 32'd0 || req_bus.resp_err !== 2'd0) begin bad++; $display("FAIL st%0d_resp got=%b/%h/%0d exp=1/0/0", i, req_bus.resp_valid, req_bus.resp_rdata, req_bus.resp_err); end
         release_resp();
      end
   endtask

   task automatic test_errors;
      logic        wens [8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [2:0]  ops [8]   = '{3'd2, 3'd3, 3'd3, 3'd7, 3'd1, 3'd1, 3'd5, 3'd2};
      logic [31:0] addrs [8] = '{32'h101, 32'h0, 32'h0, 32'h1, 32'h3, 32'h1, 32'h5, 32'h2};
      logic [1:0]  exps [8]  = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
      for (int i = 0; i < 8; i++) begin
         issue(wens[i], ops[i], addrs[i], 32'hFFFF_FFFF);
         total++; if (req_bus.resp_valid !== 1'b1 || req_bus.resp_err !== exps[i]) begin bad++; $display("FAIL err%0d_resp got=%b/%0d exp=1/%0d", i, req_bus.resp_valid, req_bus.resp_err, exps[i]); end
         total++; if (mem_bus.mem_valid !== 1'b0 || req_bus.resp_rdata !== 32'd0) begin bad++; $display("FAIL err%0d_nobus got=%b/%h exp=0/0", i, mem_bus.mem_valid, req_bus.resp_rdata); end
         // a legal request held during DONE must not be taken
         req_bus.req_wen  = 1'b0;
         req_bus.req_op   = 3'd2;
         req_bus.req_addr = 32'h0;
         req_bus.req_valid = 1'b1;
         release_resp();
         req_bus.req_valid = 1'b0;
         total++; if (req_bus.req_ready !== 1'b1 || mem_bus.mem_valid !== 1'b0) begin bad++; $display("FAIL err%0d_done_accept got=%b/%b exp=1/0", i, req_bus.req_ready, mem_bus.mem_valid); end
      end
   endtask

   task automatic test_stall;
      issue(1'b1, 3'd2, 32'h0000_0200, 32'h5A5A_1234);
      for (int c = 1; c <= 3; c++) begin
         total++; if (mem_bus.mem_valid !== 1'b1 || mem_bus.mem_addr !== 32'h200 || mem_bus.mem_wdata !== 32'h5A5A_1234 || mem_bus.mem_wmask !== 4'hF) begin bad++; $display("FAIL stall_issue%0d got=%b/%h/%h/%b exp=1/200/5a5a1234/1111", c, mem_bus.mem_valid, mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_wmask); end
         tick();
      end
      total++; if (mem_bus.mem_valid !== 1'b1) begin bad++; $display("FAIL stall_t4_valid got=%b exp=1", mem_bus.mem_valid); end
      mem_bus.mem_ready = 1'b1;
      tick();
      mem_bus.mem_ready = 1'b0;
      total++; if (req_bus.resp_valid !== 1'b0 || mem_bus.mem_valid !== 1'b0) begin bad++; $display("FAIL stall_t5 got=%b/%b exp=0/0", req_bus.resp_valid, mem_bus.mem_valid); end
      mem_bus.mem_rvalid = 1'b1;
      tick();
      mem_bus.mem_rvalid = 1'b0;
      for (int c = 6; c <= 8; c++) begin
         total++; if (req_bus.resp_valid !== 1'b1 || req_bus.resp_rdata !== 32'd0 || req_bus.resp_err !== 2'd0) begin bad++; $display("FAIL stall_resp_t%0d got=%b/%h/%0d exp=1/0/0", c, req_bus.resp_valid, req_bus.resp_rdata, req_bus.resp_err); end
         if (c < 8) tick();
      end
      release_resp();
      total++; if (req_bus.req_ready !== 1'b1 || req_bus.resp_valid !== 1'b0) begin bad++; $display("FAIL stall_idle got=%b/%b exp=1/0", req_bus.req_ready, req_bus.resp_valid); end
   endtask

   task automatic test_timeout;
      issue(1'b0, 3'd2, 32'h0000_0300, 32'd0);
      mem_bus.mem_ready = 1'b1;
      tick();
      mem_bus.mem_ready = 1'b0;
      repeat (6) tick();
      total++; if (req_bus.resp_valid !== 1'b0) begin bad++; $display("FAIL to_t8_early got=%b exp=0", req_bus.resp_valid); end
      tick();
      total++; if (req_bus.resp_valid !== 1'b1 || req_bus.resp_err !== 2'd3 || req_bus.resp_rdata !== 32'd0) begin bad++; $display("FAIL to_t9_resp got=%b/%0d/%h exp=1/3/0", req_bus.resp_valid, req_bus.resp_err, req_bus.resp_rdata); end
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = 32'hFFFF_FFFF;
      tick();
      total++; if (req_bus.resp_valid !== 1'b1 || req_bus.resp_err !== 2'd3 || req_bus.resp_rdata !== 32'd0) begin bad++; $display("FAIL to_late_rvalid got=%b/%0d/%h exp=1/3/0", req_bus.resp_valid, req_bus.resp_err, req_bus.resp_rdata); end
      release_resp();
      tick();
      mem_bus.mem_rvalid = 1'b0;
      total++; if (req_bus.req_ready !== 1'b1 || req_bus.resp_valid !== 1'b0) begin bad++; $display("FAIL to_idle got=%b/%b exp=1/0", req_bus.req_ready, req_bus.resp_valid); end
   endtask

   task automatic test_reset_midop;
      issue(1'b0, 3'd2, 32'h0000_0400, 32'd0);
      mem_bus.mem_ready = 1'b1;
      tick();
      mem_bus.mem_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++; if (req_bus.req_ready !== 1'b1 || req_bus.resp_valid !== 1'b0 || mem_bus.mem_valid !== 1'b0) begin bad++; $display("FAIL rst_wait got=%b/%b/%b exp=1/0/0", req_bus.req_ready, req_bus.resp_valid, mem_bus.mem_valid); end
      mem_bus.mem_rvalid = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      mem_bus.mem_rvalid = 1'b0;
      total++; if (req_bus.req_ready !== 1'b1 || req_bus.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_wait_after got=%b/%b exp=1/0", req_bus.req_ready, req_bus.resp_valid); end
      issue(1'b1, 3'd2, 32'h0000_0404, 32'h1);
      #1 rst_n = 1'b0;
      #1;
      total++; if (mem_bus.mem_valid !== 1'b0 || req_bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_issue got=%b/%b exp=0/1", mem_bus.mem_valid, req_bus.req_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      req_bus.req_valid  = 1'b0;
      req_bus.req_wen    = 1'b0;
      req_bus.req_op     = 3'd0;
      req_bus.req_addr   = 32'd0;
      req_bus.req_wdata  = 32'd0;
      req_bus.resp_ready = 1'b0;
      mem_bus.mem_ready  = 1'b0;
      mem_bus.mem_rvalid = 1'b0;
      mem_bus.mem_rdata  = 32'd0;
      test_reset();
      test_lb_sign();
      test_load_formats();
      test_store_lanes();
      test_errors();
      test_stall();
      test_timeout();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
